// File: rtl/gpu_launch_pkg.sv
// rtl/gpu_launch_pkg.sv - shared types and sizes for the kernel launch controller
package gpu_launch_pkg;

  localparam int KLC_DEPTH     = 1024;
  localparam int KLC_WIDTH     = 16;
  localparam int KLC_NUM_CORES = 16;
  localparam int KLC_IDX_W     = $clog2(KLC_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_LOADED = 3'd2,
    ST_LAUNCH = 3'd3,
    ST_RUN    = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERR    = 3'd6
  } klc_state_e;

endpackage

// File: rtl/klc_frame_buffer.sv
// rtl/klc_frame_buffer.sv - DEPTH x WIDTH program frame storage with whole-buffer clear
// A write in the same cycle as a clear survives; every other entry goes to zero.
module klc_frame_buffer
  import gpu_launch_pkg::*;
#(
  parameter int DEPTH = KLC_DEPTH,
  parameter int WIDTH = KLC_WIDTH
) (
  input  logic                     i_clk,
  input  logic                     i_clear,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_idx,
  input  logic [WIDTH-1:0]         i_data,
  output logic [WIDTH-1:0]         o_frames [DEPTH]
);

  localparam int IW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (i_we && (i_idx == IW'(i))) begin
        r_mem[i] <= i_data;
      end else if (i_clear) begin
        r_mem[i] <= '0;
      end
    end
  end

  assign o_frames = r_mem;

endmodule

// File: rtl/kernel_launch_ctrl.sv
// rtl/kernel_launch_ctrl.sv - loads a program into the frame buffer, launches the gpu and watches core_ready
// Optional KLC_CYCLE_COUNTER_EN adds o_run_cycles, a saturating count of RUN cycles of the last launch.
module kernel_launch_ctrl
  import gpu_launch_pkg::*;
#(
  parameter int DEPTH         = KLC_DEPTH,
  parameter int WIDTH         = KLC_WIDTH,
  parameter int NUM_CORES     = KLC_NUM_CORES,
  parameter int SETTLE_CYCLES = 4,
  parameter int TIMEOUT       = 1048576
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_host_valid,
  input  logic [WIDTH-1:0]       i_host_data,
  input  logic                   i_host_last,
  output logic                   o_host_ready,
  input  logic                   i_start,
  input  logic [NUM_CORES-1:0]   i_core_ready,
  output logic                   o_prog_loading,
  output logic [WIDTH-1:0]       o_data_frames_in [DEPTH],
  output logic [$clog2(DEPTH):0] o_frame_count,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_err
`ifdef KLC_CYCLE_COUNTER_EN
  ,
  output logic [31:0]            o_run_cycles
`endif
);

  localparam int IW = $clog2(DEPTH);
  localparam int FW = IW + 1;
  localparam int CW = $clog2(TIMEOUT) + 1;

  klc_state_e     r_state, w_state_nxt;
  logic [IW-1:0]  r_wr_ptr, w_wr_ptr_nxt;
  logic [FW-1:0]  r_frame_count, w_fc_nxt;
  logic           w_fc_load;
  logic [CW-1:0]  r_run_cnt;
  logic           w_clear, w_we, w_accept, w_core_all;
  logic [IW-1:0]  w_idx;

  assign o_host_ready = (r_state == ST_IDLE) || (r_state == ST_LOAD) ||
                        (r_state == ST_DONE) || (r_state == ST_ERR);
  assign w_accept     = i_host_valid && o_host_ready;
  assign w_core_all   = &i_core_ready;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= ST_IDLE;
      r_wr_ptr      <= '0;
      r_frame_count <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_wr_ptr <= w_wr_ptr_nxt;
      if (w_fc_load) r_frame_count <= w_fc_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_wr_ptr_nxt = r_wr_ptr;
    w_fc_load    = 1'b0;
    w_fc_nxt     = r_frame_count;
    w_clear      = 1'b0;
    w_we         = 1'b0;
    w_idx        = r_wr_ptr;
    case (r_state)
      ST_IDLE, ST_DONE, ST_ERR: begin
        // A new beat always starts a fresh load, even if start arrives alongside it.
        if (w_accept) begin
          w_clear      = 1'b1;
          w_we         = 1'b1;
          w_idx        = '0;
          w_wr_ptr_nxt = IW'(1);
          if (i_host_last) begin
            w_state_nxt = ST_LOADED;
            w_fc_load   = 1'b1;
            w_fc_nxt    = FW'(1);
          end else begin
            w_state_nxt = ST_LOAD;
          end
        end else if (i_start && (r_state != ST_IDLE)) begin
          w_state_nxt = ST_LAUNCH;
        end
      end
      ST_LOAD: begin
        if (w_accept) begin
          w_we         = 1'b1;
          w_wr_ptr_nxt = r_wr_ptr + IW'(1);
          if (i_host_last || (r_wr_ptr == IW'(DEPTH - 1))) begin
            w_state_nxt = ST_LOADED;
            w_fc_load   = 1'b1;
            w_fc_nxt    = {1'b0, r_wr_ptr} + FW'(1);
          end
        end
      end
      ST_LOADED: begin
        if (i_start) w_state_nxt = ST_LAUNCH;
      end
      ST_LAUNCH: w_state_nxt = ST_RUN;
      ST_RUN: begin
        if ((r_run_cnt >= CW'(SETTLE_CYCLES)) && w_core_all) begin
          w_state_nxt = ST_DONE;
        end else if (r_run_cnt == CW'(TIMEOUT - 1)) begin
          w_state_nxt = ST_ERR;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (i_reset) begin
      w_clear = 1'b1;
      w_we    = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_run_cnt <= '0;
    end else if (r_state == ST_LAUNCH) begin
      r_run_cnt <= '0;
    end else if (r_state == ST_RUN) begin
      r_run_cnt <= r_run_cnt + CW'(1);
    end
  end

`ifdef KLC_CYCLE_COUNTER_EN
  logic [31:0] r_run_cycles;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_run_cycles <= '0;
    end else if (r_state == ST_LAUNCH) begin
      r_run_cycles <= '0;
    end else if ((r_state == ST_RUN) && (r_run_cycles != 32'hFFFF_FFFF)) begin
      r_run_cycles <= r_run_cycles + 32'd1;
    end
  end

  assign o_run_cycles = r_run_cycles;
`endif

  assign o_prog_loading = (r_state == ST_LAUNCH);
  assign o_busy         = (r_state == ST_LOAD) || (r_state == ST_LAUNCH) || (r_state == ST_RUN);
  assign o_done         = (r_state == ST_DONE);
  assign o_err          = (r_state == ST_ERR);
  assign o_frame_count  = r_frame_count;

  klc_frame_buffer #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_frame_buffer (
    .i_clk    (i_clk),
    .i_clear  (w_clear),
    .i_we     (w_we),
    .i_idx    (w_idx),
    .i_data   (i_host_data),
    .o_frames (o_data_frames_in)
  );

endmodule

// File: tb/tb_kernel_launch_ctrl.sv
// tb/tb_kernel_launch_ctrl.sv - randomized self-checking bench for kernel_launch_ctrl
// Expected buffer contents and launch outcomes come from a frame-array model and a per-launch schedule.
module tb_kernel_launch_ctrl;

  localparam int DEPTH  = 1024;
  localparam int WIDTH  = 16;
  localparam int NC     = 16;
  localparam int SETTLE = 4;
  localparam int TMO    = 64;

  logic             clk = 1'b0;
  logic             reset, host_valid, host_last, start;
  logic [WIDTH-1:0] host_data;
  logic [NC-1:0]    core_ready;
  logic             host_ready, prog_loading, busy, done, err;
  logic [WIDTH-1:0] frames [DEPTH];
  logic [10:0]      frame_count;
`ifdef KLC_CYCLE_COUNTER_EN
  logic [31:0]      run_cycles;
`endif

  int               n_checks = 0;
  int               n_fail   = 0;
  logic [WIDTH-1:0] exp_buf [DEPTH];
  int               exp_fc;

  always #5 clk = ~clk;

  kernel_launch_ctrl #(
    .DEPTH(DEPTH), .WIDTH(WIDTH), .NUM_CORES(NC), .SETTLE_CYCLES(SETTLE), .TIMEOUT(TMO)
  ) dut (
    .i_clk            (clk),
    .i_reset          (reset),
    .i_host_valid     (host_valid),
    .i_host_data      (host_data),
    .i_host_last      (host_last),
    .o_host_ready     (host_ready),
    .i_start          (start),
    .i_core_ready     (core_ready),
    .o_prog_loading   (prog_loading),
    .o_data_frames_in (frames),
    .o_frame_count    (frame_count),
    .o_busy           (busy),
    .o_done           (done),
    .o_err            (err)
`ifdef KLC_CYCLE_COUNTER_EN
    ,
    .o_run_cycles     (run_cycles)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) exp_buf[i] = '0;
  endtask

  task automatic check_buf(input string tag);
    int bad = 0;
    for (int i = 0; i < DEPTH; i++) if (frames[i] !== exp_buf[i]) bad++;
    check(tag, bad, 0);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1; host_valid = 1'b0; host_last = 1'b0; start = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    model_clear();
    exp_fc = 0;
    check({tag, "_ready"}, host_ready, 1);
    check({tag, "_pl"}, prog_loading, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_fc"}, frame_count, 0);
    check_buf({tag, "_buf"});
`ifdef KLC_CYCLE_COUNTER_EN
    check({tag, "_cycles"}, run_cycles, 0);
`endif
  endtask

  // Sends beats k0..n-1; beat 0 clears the model buffer. Loads of DEPTH beats may omit host_last.
  task automatic do_load(input int k0, input int n, input bit use_last, input bit fixed, input bit poke);
    for (int k = k0; k < n; k++) begin
      check("load_ready", host_ready, 1);
      host_valid = 1'b1;
      host_data  = fixed ? WIDTH'(k + 1) : WIDTH'($urandom);
      host_last  = use_last && (k == n - 1);
      start      = poke ? 1'($urandom_range(0, 1)) : 1'b0;
      if (k == 0) model_clear();
      exp_buf[k] = host_data;
      tick();
    end
    host_valid = 1'b0; host_last = 1'b0; start = 1'b0;
    exp_fc = n;
    check("loaded_ready", host_ready, 0);
    check("loaded_busy", busy, 0);
    check("loaded_pl", prog_loading, 0);
    check("loaded_fc", frame_count, exp_fc);
    check_buf("loaded_buf");
  endtask

  task automatic ignored_beat();
    host_valid = 1'b1; host_data = 16'hBEEF; host_last = 1'b1;
    tick();
    host_valid = 1'b0; host_last = 1'b0;
    check("ign_ready", host_ready, 0);
    check("ign_fc", frame_count, exp_fc);
    check_buf("ign_buf");
  endtask

  // mode 0: random core_ready, 1: all idle throughout, 2: one core never idle
  task automatic run_launch(input int mode);
    logic [NC-1:0] sched [TMO];
    int  jstar = TMO - 1;
    bit  exp_done = 1'b0;
    for (int j = 0; j < TMO; j++) begin
      case (mode)
        0:       sched[j] = ($urandom_range(0, 3) == 0) ? 16'hFFFF : NC'($urandom);
        1:       sched[j] = 16'hFFFF;
        default: sched[j] = 16'hFFFE;
      endcase
    end
    if (mode == 0) sched[1] = 16'hFFFF;
    for (int j = SETTLE; j < TMO; j++) begin
      if (sched[j] == 16'hFFFF) begin
        jstar = j;
        exp_done = 1'b1;
        break;
      end
    end
    start = 1'b1; core_ready = 16'hFFFF;
    tick();
    start = 1'b0;
    check("launch_pl", prog_loading, 1);
    check("launch_busy", busy, 1);
    check("launch_ready", host_ready, 0);
    tick();
    check("run0_pl", prog_loading, 0);
    check("run0_busy", busy, 1);
    for (int j = 0; j <= jstar; j++) begin
      core_ready = sched[j];
      tick();
      if (j < jstar) begin
        check("run_busy", busy, 1);
        check("run_done", done, 0);
        check("run_pl", prog_loading, 0);
      end else begin
        check("end_done", done, exp_done);
        check("end_err", err, !exp_done);
        check("end_busy", busy, 0);
        check("end_ready", host_ready, 1);
      end
    end
`ifdef KLC_CYCLE_COUNTER_EN
    check("run_cycles", run_cycles, jstar + 1);
`endif
    check_buf("run_buf");
    check("run_fc", frame_count, exp_fc);
    core_ready = '0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    host_data = '0; core_ready = '0;
    do_reset("rst0");

    start = 1'b1;
    tick();
    start = 1'b0;
    check("idle_start_pl", prog_loading, 0);
    check("idle_start_busy", busy, 0);

    do_load(0, 3, 1'b1, 1'b1, 1'b0);
    check("short_e2", frames[2], 3);
    ignored_beat();
    run_launch(1);
    run_launch(0);
    run_launch(2);

    do_load(0, DEPTH, 1'b0, 1'b0, 1'b1);
    ignored_beat();
    run_launch(0);

    host_valid = 1'b1; start = 1'b1; host_last = 1'b0; host_data = 16'h00AA;
    model_clear();
    exp_buf[0] = 16'h00AA;
    tick();
    host_valid = 1'b0; start = 1'b0;
    check("both_pl", prog_loading, 0);
    check("both_busy", busy, 1);
    check("both_ready", host_ready, 1);
    check_buf("both_buf");
    do_load(1, 1 + $urandom_range(1, 20), 1'b1, 1'b0, 1'b1);
    run_launch(1);

    for (int r = 0; r < 3; r++) begin
      do_load(0, $urandom_range(1, 40), 1'b1, 1'b0, 1'b1);
      run_launch(0);
    end

    for (int k = 0; k < 5; k++) begin
      host_valid = 1'b1; host_data = WIDTH'($urandom); host_last = 1'b0;
      tick();
    end
    do_reset("rst_load");

    do_load(0, 4, 1'b1, 1'b0, 1'b0);
    start = 1'b1; core_ready = 16'hFFFE;
    tick();
    start = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    check("midrun_busy", busy, 1);
    do_reset("rst_run");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
